frame_scheduler: RTL and testbench

- Shares one `frame_controller` between `NUM_REQ` descriptor sources.
- Arbitrates among pending frame requests and latches the winner's descriptor (base address, depth, lane stride, exec hints).
- Pulses the controller's start trigger, waits for frame completion, then returns a per-requester completion pulse.
- Sits between the host/DMA descriptor queues and the frame controller; it is the only block that drives the controller's configuration inputs.

---
 rtl/frame_scheduler_if.sv | 38 +++
 rtl/frame_scheduler.sv | 163 ++++++++++++++++
 tb/tb_frame_scheduler.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/frame_scheduler_if.sv
// -----------------------------------------------------------------------------
// frame_scheduler_if
//   Requester-side bundle of the frame scheduler: descriptor queues present
//   packed descriptors and a valid bit per requester; the scheduler returns a
//   one-hot ready (grant) and a one-cycle per-requester completion pulse.
//
//   Handshake: requester i transfers its descriptor on the rising clock edge
//   where req_valid[i] & req_ready[i] is 1. A requester may drop req_valid at
//   any time before that edge. done_valid is a single-cycle pulse, never
//   multi-hot, and done_err qualifies it (1 = descriptor rejected).
//
//   Modports:
//     master - descriptor source side (drives req_*, observes ready/done)
//     slave  - scheduler side
// -----------------------------------------------------------------------------
interface frame_scheduler_if #(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = 32
);
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_ready;
    logic [NUM_REQ*ADDR_WIDTH-1:0] req_base_addr;
    logic [NUM_REQ*16-1:0]         req_frame_depth;
    logic [NUM_REQ*8-1:0]          req_lane_stride;
    logic [NUM_REQ*32-1:0]         req_exec_hints;
    logic [NUM_REQ-1:0]            done_valid;
    logic                          done_err;

    modport master (
        output req_valid, req_base_addr, req_frame_depth, req_lane_stride, req_exec_hints,
        input  req_ready, done_valid, done_err
    );

    modport slave (
        input  req_valid, req_base_addr, req_frame_depth, req_lane_stride, req_exec_hints,
        output req_ready, done_valid, done_err
    );
endinterface

// File: rtl/frame_scheduler.sv
// -----------------------------------------------------------------------------
// frame_scheduler
//   Shares one frame_controller between NUM_REQ descriptor sources. In IDLE a
//   round-robin arbiter picks a pending request, the winner's descriptor is
//   latched into the fc_* registers, the controller is started with a
//   one-cycle pulse, and on controller completion a one-cycle done pulse is
//   returned to the owning requester. Zero-depth descriptors are rejected
//   without launching (the controller would underflow depth-1).
//
//   Ports:
//     clk, reset_n          clock, asynchronous active-low reset
//     req_if (slave)        requester handshake, descriptors, done pulse
//     busy                  high in every state except IDLE
//     active_id             requester owning the controller
//     frames_done           frames retired without error (wraps)
//     fc_*                  held descriptor + start pulse to the controller
//     fc_frame_done         controller completion pulse (only honoured in WAIT)
//     dbg_state             current FSM state (IDLE=0 LAUNCH=1 WAIT=2 RETIRE=3)
//
//   Build option:
//     FRAME_SCHED_PRIO0_EN  requester 0 gets strict priority; its grants leave
//                           the round-robin pointer untouched.
// -----------------------------------------------------------------------------
module frame_scheduler #(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int ID_W       = $clog2(NUM_REQ)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    frame_scheduler_if.slave      req_if,
    output logic                  busy,
    output logic [ID_W-1:0]       active_id,
    output logic [15:0]           frames_done,
    output logic [ADDR_WIDTH-1:0] fc_base_addr,
    output logic [15:0]           fc_frame_depth,
    output logic [7:0]            fc_lane_stride,
    output logic [31:0]           fc_exec_hints,
    output logic                  fc_start_trigger,
    input  logic                  fc_frame_done,
    output logic [1:0]            dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LAUNCH = 2'd1,
        S_WAIT   = 2'd2,
        S_RETIRE = 2'd3
    } state_t;

    state_t               state;
    logic [ID_W-1:0]      last_grant;
    logic                 err_flag;
    logic [NUM_REQ-1:0]   done_valid_q;
    logic                 done_err_q;

    logic                 grant_found;
    logic                 grant_prio;
    logic [ID_W-1:0]      grant_id;
    logic [ID_W-1:0]      search_idx;
    logic [NUM_REQ-1:0]   grant_onehot;
    logic [NUM_REQ-1:0]   active_onehot;
    logic [15:0]          sel_depth;

    // Arbiter: search starts one past the last winner and wraps modulo
    // NUM_REQ, so the previous winner is considered last.
    always_comb begin
        grant_found = 1'b0;
        grant_prio  = 1'b0;
        grant_id    = '0;
        search_idx  = '0;
`ifdef FRAME_SCHED_PRIO0_EN
        if (req_if.req_valid[0]) begin
            grant_found = 1'b1;
            grant_prio  = 1'b1;
        end
`endif
        for (int k = 1; k <= NUM_REQ; k++) begin
            search_idx = ID_W'((int'(last_grant) + k) % NUM_REQ);
            if (!grant_found && req_if.req_valid[search_idx]) begin
                grant_found = 1'b1;
                grant_id    = search_idx;
            end
        end
    end

    assign grant_onehot  = {{(NUM_REQ-1){1'b0}}, 1'b1} << grant_id;
    assign active_onehot = {{(NUM_REQ-1){1'b0}}, 1'b1} << active_id;
    assign sel_depth     = req_if.req_frame_depth[int'(grant_id)*16 +: 16];

    // Ready is only ever offered in IDLE; outside IDLE no handshake can occur.
    assign req_if.req_ready  = (state == S_IDLE && grant_found) ? grant_onehot : '0;
    assign req_if.done_valid = done_valid_q;
    assign req_if.done_err   = done_err_q;
    assign busy              = (state != S_IDLE);
    assign dbg_state         = state;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state            <= S_IDLE;
            last_grant       <= ID_W'(NUM_REQ - 1);
            err_flag         <= 1'b0;
            done_valid_q     <= '0;
            done_err_q       <= 1'b0;
            active_id        <= '0;
            frames_done      <= '0;
            fc_base_addr     <= '0;
            fc_frame_depth   <= '0;
            fc_lane_stride   <= '0;
            fc_exec_hints    <= '0;
            fc_start_trigger <= 1'b0;
        end else begin
            // Pulsed outputs default low every cycle.
            fc_start_trigger <= 1'b0;
            done_valid_q     <= '0;
            done_err_q       <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (grant_found) begin
                        fc_base_addr   <= req_if.req_base_addr[int'(grant_id)*ADDR_WIDTH +: ADDR_WIDTH];
                        fc_frame_depth <= sel_depth;
                        fc_lane_stride <= req_if.req_lane_stride[int'(grant_id)*8 +: 8];
                        fc_exec_hints  <= req_if.req_exec_hints[int'(grant_id)*32 +: 32];
                        active_id      <= grant_id;
                        if (!grant_prio) begin
                            last_grant <= grant_id;
                        end
                        if (sel_depth == 16'd0) begin
                            // Reject without launching; report in the next cycle.
                            err_flag     <= 1'b1;
                            done_valid_q <= grant_onehot;
                            done_err_q   <= 1'b1;
                            state        <= S_RETIRE;
                        end else begin
                            fc_start_trigger <= 1'b1;
                            state            <= S_LAUNCH;
                        end
                    end
                end
                S_LAUNCH: begin
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (fc_frame_done) begin
                        done_valid_q <= active_onehot;
                        done_err_q   <= err_flag;
                        state        <= S_RETIRE;
                    end
                end
                S_RETIRE: begin
                    if (!err_flag) begin
                        frames_done <= frames_done + 16'd1;
                    end
                    err_flag <= 1'b0;
                    state    <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_frame_scheduler.sv
module tb_frame_scheduler;

    localparam int NUM_REQ    = 4;
    localparam int ADDR_WIDTH = 32;
    localparam int NV         = 7;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        busy;
    logic [1:0]  active_id;
    logic [15:0] frames_done;
    logic [31:0] fc_base_addr;
    logic [15:0] fc_frame_depth;
    logic [7:0]  fc_lane_stride;
    logic [31:0] fc_exec_hints;
    logic        fc_start_trigger;
    logic        fc_frame_done = 1'b0;
    logic [1:0]  dbg_state;

    int checks   = 0;
    int failures = 0;
    int trig_cnt = 0;
    int done_cnt = 0;
    int exp_frames = 0;

    frame_scheduler_if #(.NUM_REQ(NUM_REQ), .ADDR_WIDTH(ADDR_WIDTH)) bus ();

    frame_scheduler #(.NUM_REQ(NUM_REQ), .ADDR_WIDTH(ADDR_WIDTH)) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .req_if           (bus),
        .busy             (busy),
        .active_id        (active_id),
        .frames_done      (frames_done),
        .fc_base_addr     (fc_base_addr),
        .fc_frame_depth   (fc_frame_depth),
        .fc_lane_stride   (fc_lane_stride),
        .fc_exec_hints    (fc_exec_hints),
        .fc_start_trigger (fc_start_trigger),
        .fc_frame_done    (fc_frame_done),
        .dbg_state        (dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // Pulse counters and one-hot check on done, sampled mid-cycle.
    always @(negedge clk) begin
        if (fc_start_trigger) trig_cnt++;
        if (|bus.done_valid) begin
            done_cnt++;
            checks++;
            if ($countones(bus.done_valid) != 1) begin
                failures++;
                $display("FAIL done_onehot actual=%b required=one-hot", bus.done_valid);
            end
        end
    end

    // ---------------- scoreboard helpers ----------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Requester i gets base+i*0x100, stride i+1, hints+i; depth is shared.
    task automatic set_req(input logic [3:0] valid, input logic [15:0] depth,
                           input logic [31:0] base, input logic [31:0] hints);
        for (int i = 0; i < NUM_REQ; i++) begin
            bus.req_base_addr[i*32 +: 32]  = base + 32'(i) * 32'h100;
            bus.req_frame_depth[i*16 +: 16] = depth;
            bus.req_lane_stride[i*8 +: 8]  = 8'(i + 1);
            bus.req_exec_hints[i*32 +: 32] = hints + 32'(i);
        end
        bus.req_valid = valid;
    endtask

    task automatic wait_trigger(output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            if (fc_start_trigger) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL trigger_timeout actual=no_start required=start_within_40");
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [3:0]  valid;
        logic [15:0] depth;
        logic [31:0] base;
        logic [31:0] hints;
        int          exp_id;
        logic        exp_err;
        int          exp_frames;
    } vec_t;

    vec_t vecs[NV];

    initial begin
        logic [3:0] oh;
        bit         ok;
        int         t0;
        int         d0;
        int         order[8];
        logic [3:0] masks[8];
        int         nfr;

        // last_grant starts at 3; expected winners traced by hand.
        vecs[0] = '{4'b0100, 16'd4, 32'h0000_0E00, 32'h1111_0000, 2, 1'b0, 1};
        vecs[1] = '{4'b0010, 16'd0, 32'h0000_2000, 32'h2222_0000, 1, 1'b1, 1};
`ifdef FRAME_SCHED_PRIO0_EN
        vecs[2] = '{4'b1111, 16'd2, 32'h0000_3000, 32'h3333_0000, 0, 1'b0, 2};
        vecs[3] = '{4'b1011, 16'd1, 32'h0000_4000, 32'h4444_0000, 0, 1'b0, 3};
        vecs[5] = '{4'b1001, 16'd0, 32'h0000_6000, 32'h6666_0000, 0, 1'b1, 4};
`else
        vecs[2] = '{4'b1111, 16'd2, 32'h0000_3000, 32'h3333_0000, 2, 1'b0, 2};
        vecs[3] = '{4'b1011, 16'd1, 32'h0000_4000, 32'h4444_0000, 3, 1'b0, 3};
        vecs[5] = '{4'b1001, 16'd0, 32'h0000_6000, 32'h6666_0000, 3, 1'b1, 4};
`endif
        vecs[4] = '{4'b0011, 16'd3, 32'h0000_5000, 32'h5555_0000, 0, 1'b0, 4};
        vecs[6] = '{4'b0001, 16'd5, 32'h0000_7000, 32'h7777_0000, 0, 1'b0, 5};

        // ---------------- reset ----------------
        set_req(4'b0000, 16'd0, 32'h0, 32'h0);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_state", dbg_state, 0);
        chk("rst_ready", bus.req_ready, 0);
        chk("rst_done", bus.done_valid, 0);
        chk("rst_fc_base", fc_base_addr, 0);
        chk("rst_trigger", fc_start_trigger, 0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;
        chk("idle_active_id", active_id, 0);
        chk("idle_frames", frames_done, 0);
        chk("idle_fc_hints", fc_exec_hints, 0);

        // ---------------- table-driven frames ----------------
        for (int v = 0; v < NV; v++) begin
            t0 = trig_cnt;
            set_req(vecs[v].valid, vecs[v].depth, vecs[v].base, vecs[v].hints);
            oh = 4'b0001 << vecs[v].exp_id;
            #1;
            chk($sformatf("v%0d_ready", v), bus.req_ready, oh);
            @(posedge clk); #1;                   // cycle T+1
            bus.req_valid = 4'b0000;
            chk($sformatf("v%0d_active_id", v), active_id, vecs[v].exp_id);
            chk($sformatf("v%0d_fc_base", v), fc_base_addr,
                vecs[v].base + 32'(vecs[v].exp_id) * 32'h100);
            chk($sformatf("v%0d_fc_depth", v), fc_frame_depth, vecs[v].depth);
            chk($sformatf("v%0d_fc_stride", v), fc_lane_stride, vecs[v].exp_id + 1);
            chk($sformatf("v%0d_fc_hints", v), fc_exec_hints,
                vecs[v].hints + 32'(vecs[v].exp_id));
            if (vecs[v].depth != 16'd0) begin
                chk($sformatf("v%0d_trigger", v), fc_start_trigger, 1);
                repeat (int'(vecs[v].depth)) @(posedge clk);
                #1;
                fc_frame_done = 1'b1;
                @(posedge clk); #1;               // cycle D+1
                fc_frame_done = 1'b0;
                chk($sformatf("v%0d_done_valid", v), bus.done_valid, oh);
                chk($sformatf("v%0d_done_err", v), bus.done_err, 0);
            end else begin
                chk($sformatf("v%0d_no_trigger", v), fc_start_trigger, 0);
                chk($sformatf("v%0d_done_valid", v), bus.done_valid, oh);
                chk($sformatf("v%0d_done_err", v), bus.done_err, 1);
            end
            @(posedge clk); #1;
            chk($sformatf("v%0d_done_clear", v), bus.done_valid, 0);
            chk($sformatf("v%0d_idle", v), busy, 0);
            chk($sformatf("v%0d_frames", v), frames_done, vecs[v].exp_frames);
            chk($sformatf("v%0d_trig_count", v), trig_cnt - t0,
                (vecs[v].depth != 16'd0) ? 1 : 0);
        end

        // ---------------- reset in the middle of a frame ----------------
        set_req(4'b0100, 16'd10, 32'h0000_2000, 32'h0000_0055);
        @(posedge clk); #1;
        bus.req_valid = 4'b0000;
        @(posedge clk); #1;
        chk("mid_state_wait", dbg_state, 2);
        #2;
        reset_n = 1'b0;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_state", dbg_state, 0);
        chk("mid_rst_fc_base", fc_base_addr, 0);
        chk("mid_rst_active", active_id, 0);
        chk("mid_rst_frames", frames_done, 0);
        exp_frames = 0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        d0 = done_cnt;
        fc_frame_done = 1'b1;
        @(posedge clk); #1;
        fc_frame_done = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("mid_rst_no_done", done_cnt - d0, 0);
        chk("mid_rst_idle", dbg_state, 0);

        // ---------------- fairness / priority with continuous valid ----------------
`ifdef FRAME_SCHED_PRIO0_EN
        nfr = 5;
        order = '{0, 0, 0, 0, 3, 0, 0, 0};
        masks = '{4'b1001, 4'b1001, 4'b1001, 4'b1001, 4'b1000, 4'b0, 4'b0, 4'b0};
`else
        nfr = 8;
        order = '{0, 1, 2, 3, 0, 1, 2, 3};
        masks = '{4'b1111, 4'b1111, 4'b1111, 4'b1111, 4'b1111, 4'b1111, 4'b1111, 4'b1111};
`endif
        set_req(masks[0], 16'd1, 32'h0000_4000, 32'h0);
        for (int k = 0; k < nfr; k++) begin
            wait_trigger(ok);
            if (!ok) break;
            chk($sformatf("rr%0d_active_id", k), active_id, order[k]);
            chk($sformatf("rr%0d_fc_base", k), fc_base_addr, 32'h4000 + 32'(order[k]) * 32'h100);
            @(posedge clk); #1;                   // WAIT
            fc_frame_done = 1'b1;
            @(posedge clk); #1;                   // RETIRE
            fc_frame_done = 1'b0;
            oh = 4'b0001 << order[k];
            chk($sformatf("rr%0d_done_valid", k), bus.done_valid, oh);
            chk($sformatf("rr%0d_ready_low", k), bus.req_ready, 0);
            exp_frames++;
            if (k + 1 < nfr) bus.req_valid = masks[k + 1];
            else bus.req_valid = 4'b0000;
        end
        @(posedge clk); #1;
        chk("rr_frames", frames_done, exp_frames);

        // ---------------- spurious done in IDLE ----------------
        d0 = done_cnt;
        fc_frame_done = 1'b1;
        @(posedge clk); #1;
        fc_frame_done = 1'b0;
        chk("spur_state", dbg_state, 0);
        chk("spur_busy", busy, 0);
        @(posedge clk); #1;
        chk("spur_no_done", done_cnt - d0, 0);

        // ---------------- descriptor held during WAIT ----------------
        set_req(4'b0010, 16'd3, 32'h0000_8000, 32'hCAFE_0000);
        @(posedge clk); #1;
        bus.req_valid = 4'b0000;
        chk("hold_trigger", fc_start_trigger, 1);
        set_req(4'b1111, 16'd7, 32'h0000_9000, 32'hDEAD_BEEF);
        @(posedge clk); #1;                       // WAIT
        chk("hold_state_wait", dbg_state, 2);
        chk("hold_ready_low", bus.req_ready, 0);
        chk("hold_fc_hints", fc_exec_hints, 32'hCAFE_0001);
        chk("hold_fc_base", fc_base_addr, 32'h0000_8100);
        chk("hold_fc_depth", fc_frame_depth, 16'd3);
        bus.req_valid = 4'b0000;
        @(posedge clk); #1;
        chk("hold_fc_hints2", fc_exec_hints, 32'hCAFE_0001);
        fc_frame_done = 1'b1;
        @(posedge clk); #1;
        fc_frame_done = 1'b0;
        chk("hold_done_valid", bus.done_valid, 4'b0010);
        chk("hold_done_err", bus.done_err, 0);
        exp_frames++;
        @(posedge clk); #1;
        chk("hold_frames", frames_done, exp_frames);
        chk("hold_fc_kept", fc_base_addr, 32'h0000_8100);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
